// File: rtl/expand_1x1_engine.sv
// ---------------------------------------------------------------------------
// expand_1x1_engine
//
// Purpose:
//   1x1 convolution engine for fire-module expand layers. Input channels of
//   one pixel arrive one per beat; DSP_NO parallel MAC lanes accumulate
//   ifm * weight over CHIN channels, add a per-lane bias, apply ReLU and
//   saturating requantisation (>>> FRAC), and emit one DSP_NO-lane output
//   vector per pixel. A per-layer weight/bias context is chosen at start.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - single-cycle start request (honoured only when idle)
//   layer_sel    - layer context, sampled when start is accepted
//   ifm_valid    - input beat valid
//   ifm          - one input-channel value (channel order 0..CHIN-1)
//   ifm_ready    - high while streaming input (RUN)
//   w_layer      - latched layer index to weight ROM / bias table
//   w_addr       - current channel index to weight ROM
//   w_data       - combinational ROM data, lane i = [i*WIDTH +: WIDTH]
//   bias         - per-lane bias in product scale, lane i = [i*2*WIDTH +: 2*WIDTH]
//   ofm          - output vector, held between valids
//   ofm_valid    - one-cycle pulse per pixel
//   busy         - engine active
//   done         - one-cycle pulse with the final ofm_valid of a layer
// ---------------------------------------------------------------------------
module expand_1x1_engine #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 64,
    parameter int CHIN   = 16,
    parameter int WOUT   = 64,
    parameter int FRAC   = 14,
    parameter int LAYERS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(LAYERS)-1:0]     layer_sel,
    input  logic                          ifm_valid,
    input  logic [WIDTH-1:0]              ifm,
    output logic                          ifm_ready,
    output logic [$clog2(LAYERS)-1:0]     w_layer,
    output logic [$clog2(CHIN)-1:0]       w_addr,
    input  logic [DSP_NO*WIDTH-1:0]       w_data,
    input  logic [DSP_NO*2*WIDTH-1:0]     bias,
    output logic [DSP_NO*WIDTH-1:0]       ofm,
    output logic                          ofm_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int LW    = $clog2(LAYERS);
    localparam int CW    = $clog2(CHIN);
    localparam int NPIX  = WOUT * WOUT;
    localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PRODW = 2 * WIDTH;
    localparam int ACCW  = PRODW + CW;
    localparam int SUMW  = ACCW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                 r_state;
    logic [LW-1:0]          r_layer;
    logic [CW-1:0]          r_ch_cnt;
    logic [PW-1:0]          r_pix_cnt;

    logic                   w_accept;
    logic                   w_ch_last;
    logic                   w_pix_last;

    // Stage 1: registered beat
    logic signed [WIDTH-1:0] r_s1_ifm;
    logic [DSP_NO*WIDTH-1:0] r_s1_w;
    logic                    r_s1_valid;
    logic                    r_s1_first;
    logic                    r_s1_last;
    logic                    r_s1_end;

    // Stage 2: accumulators
    logic signed [ACCW-1:0]  r_acc [DSP_NO];
    logic                    r_s2_valid;
    logic                    r_s2_last;
    logic                    r_s2_end;

    // Stage 3: output
    logic [DSP_NO*WIDTH-1:0] r_ofm;
    logic                    r_ofm_valid;
    logic                    r_done;

    logic signed [PRODW-1:0] w_prod [DSP_NO];
    logic signed [ACCW-1:0]  w_prod_ext [DSP_NO];
    logic signed [SUMW-1:0]  w_sum [DSP_NO];
    logic signed [SUMW-1:0]  w_q [DSP_NO];
    logic [DSP_NO*WIDTH-1:0] w_res;

    assign ifm_ready  = (r_state == S_RUN);
    assign busy       = (r_state != S_IDLE);
    assign w_accept   = ifm_valid && ifm_ready;
    assign w_ch_last  = (r_ch_cnt == CW'(CHIN - 1));
    assign w_pix_last = (r_pix_cnt == PW'(NPIX - 1));

    assign w_layer    = r_layer;
    assign w_addr     = r_ch_cnt;
    assign ofm        = r_ofm;
    assign ofm_valid  = r_ofm_valid;
    assign done       = r_done;

    // Control FSM: channel/pixel counters advance only on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_layer   <= '0;
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_layer   <= layer_sel;
                        r_ch_cnt  <= '0;
                        r_pix_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_ch_last) begin
                            r_ch_cnt <= '0;
                            if (w_pix_last) begin
                                r_pix_cnt <= '0;
                                r_state   <= S_FLUSH;
                            end else begin
                                r_pix_cnt <= r_pix_cnt + PW'(1);
                            end
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // r_done marks the final pixel leaving the pipeline
                    if (r_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Products, bias add, ReLU and saturating requantisation
    always_comb begin
        w_prod     = '{default: '0};
        w_prod_ext = '{default: '0};
        w_sum      = '{default: '0};
        w_q        = '{default: '0};
        w_res      = '0;
        for (int unsigned i = 0; i < DSP_NO; i++) begin
            w_prod[i]     = PRODW'(r_s1_ifm) * PRODW'($signed(r_s1_w[i*WIDTH +: WIDTH]));
            w_prod_ext[i] = ACCW'(w_prod[i]);
            w_sum[i]      = SUMW'(r_acc[i]) + SUMW'($signed(bias[i*PRODW +: PRODW]));
            w_q[i]        = w_sum[i] >>> FRAC;
            if (w_sum[i][SUMW-1]) begin
                w_res[i*WIDTH +: WIDTH] = '0;
            end else if (|w_q[i][SUMW-1:WIDTH-1]) begin
                // non-negative value above the signed max
                w_res[i*WIDTH +: WIDTH] = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                w_res[i*WIDTH +: WIDTH] = w_q[i][WIDTH-1:0];
            end
        end
    end

    // Three-stage datapath; stages advance every cycle so latency is fixed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_ifm    <= '0;
            r_s1_w      <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_end    <= 1'b0;
            for (int unsigned i = 0; i < DSP_NO; i++) begin
                r_acc[i] <= '0;
            end
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_end    <= 1'b0;
            r_ofm       <= '0;
            r_ofm_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ifm   <= $signed(ifm);
                r_s1_w     <= w_data;
                r_s1_first <= (r_ch_cnt == '0);
                r_s1_last  <= w_ch_last;
                r_s1_end   <= w_ch_last && w_pix_last;
            end

            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                for (int unsigned i = 0; i < DSP_NO; i++) begin
                    r_acc[i] <= r_s1_first ? w_prod_ext[i] : (r_acc[i] + w_prod_ext[i]);
                end
                r_s2_last <= r_s1_last;
                r_s2_end  <= r_s1_end;
            end

            // The accumulator is read here before the next pixel's first
            // beat overwrites it, so pixels run back-to-back.
            r_ofm_valid <= r_s2_valid && r_s2_last;
            r_done      <= r_s2_valid && r_s2_last && r_s2_end;
            if (r_s2_valid && r_s2_last) begin
                r_ofm <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_expand_1x1_engine.sv
module tb_expand_1x1_engine;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 4;
    localparam int CHIN   = 4;
    localparam int WOUT   = 2;
    localparam int FRAC   = 14;
    localparam int LAYERS = 2;
    localparam int NPIX   = WOUT * WOUT;
    localparam int NBEAT  = NPIX * CHIN;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic [0:0]                 layer_sel = 1'b0;
    logic                       ifm_valid = 1'b0;
    logic [WIDTH-1:0]           ifm = '0;
    logic                       ifm_ready;
    logic [0:0]                 w_layer;
    logic [1:0]                 w_addr;
    logic [DSP_NO*WIDTH-1:0]    w_data;
    logic [DSP_NO*2*WIDTH-1:0]  bias;
    logic [DSP_NO*WIDTH-1:0]    ofm;
    logic                       ofm_valid;
    logic                       busy;
    logic                       done;

    logic [WIDTH-1:0] rom [LAYERS][CHIN][DSP_NO];
    int               bias_l [DSP_NO];
    logic [WIDTH-1:0] px [NBEAT];
    logic [63:0]      exp_pix [NPIX];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Weight ROM and bias table
    always_comb begin
        w_data = '0;
        for (int i = 0; i < DSP_NO; i++) w_data[i*WIDTH +: WIDTH] = rom[w_layer][w_addr][i];
    end
    always_comb begin
        bias = '0;
        for (int i = 0; i < DSP_NO; i++) bias[i*2*WIDTH +: 2*WIDTH] = bias_l[i];
    end

    expand_1x1_engine #(
        .WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN),
        .WOUT(WOUT), .FRAC(FRAC), .LAYERS(LAYERS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
        .ifm_valid(ifm_valid), .ifm(ifm), .ifm_ready(ifm_ready),
        .w_layer(w_layer), .w_addr(w_addr), .w_data(w_data), .bias(bias),
        .ofm(ofm), .ofm_valid(ofm_valid), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ofm"}, ofm, 64'(0));
        chk({tag, "_ctl"}, 64'({ofm_valid, done, busy, ifm_ready, w_layer, w_addr}), 64'(0));
    endtask

    // Reference: dot product + bias in plain integer arithmetic, then ReLU/saturate
    function automatic logic [63:0] model_pixel(input int l, input int p);
        logic [63:0] r = '0;
        for (int lane = 0; lane < DSP_NO; lane++) begin
            longint s = longint'(bias_l[lane]);
            longint v;
            for (int c = 0; c < CHIN; c++)
                s += longint'($signed(px[p*CHIN+c])) * longint'($signed(rom[l][c][lane]));
            if (s < 0) v = 0;
            else begin
                v = s >>> FRAC;
                if (v > 32767) v = 32767;
            end
            r[lane*WIDTH +: WIDTH] = 16'(v);
        end
        return r;
    endfunction

    task automatic run_layer(input logic [0:0] lsel, input bit stall, input bit poke, input int rst_beat);
        int beat = 0;
        int pix_out = 0;
        int final_cyc = -1;
        bit done_seen = 0;
        bit ended = 0;
        bit v;
        int lc;
        int lastq[$];
        start = 1'b1;
        layer_sel = lsel;
        ifm_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 64'({busy, ifm_ready}), 64'(2'b11));
        for (int n = 0; n < 300 && !ended; n++) begin
            if (done_seen) begin
                chk("busy_fall", 64'(busy), 64'(0));
                ended = 1;
            end else begin
                if (ofm_valid) begin
                    if (pix_out < NPIX) chk("ofm", ofm, exp_pix[pix_out]);
                    else chk("extra_ofm", 64'(pix_out), 64'(NPIX - 1));
                    lc = (lastq.size() > 0) ? lastq.pop_front() : -100;
                    chk("latency", 64'(n), 64'(lc + 3));
                    pix_out++;
                    chk("done_with_last", 64'(done), 64'(pix_out == NPIX));
                end else if (done) begin
                    chk("done_alone", 64'(done), 64'(0));
                end
                if (done) done_seen = 1;
                if (final_cyc >= 0 && n == final_cyc + 1) chk("ready_drop", 64'(ifm_ready), 64'(0));
                if (ifm_ready) begin
                    chk("w_addr", 64'(w_addr), 64'(beat % CHIN));
                    chk("w_layer", 64'(w_layer), 64'(lsel));
                end
                start = poke && (n == 5);
                layer_sel = poke ? ~lsel : lsel;
                v = (beat < NBEAT) && !(stall && (n inside {2, 3, 4, 7}));
                ifm_valid = v;
                ifm = v ? px[beat] : '0;
                if (rst_beat >= 0 && beat == rst_beat && ifm_ready) begin
                    #3 rst = 1'b1;
                    #1 chk_zero("rst_mid");
                    @(posedge clk); #1;
                    chk_zero("rst_hold");
                    rst = 1'b0;
                    ifm_valid = 1'b0;
                    start = 1'b0;
                    layer_sel = lsel;
                    chk("no_done", 64'(done_seen), 64'(0));
                    return;
                end
                if (v && ifm_ready) begin
                    if (beat % CHIN == CHIN - 1) lastq.push_back(n);
                    if (beat == NBEAT - 1) final_cyc = n;
                    beat++;
                end
                @(posedge clk); #1;
            end
        end
        chk("finished", 64'(ended), 64'(1));
        chk("pix_count", 64'(pix_out), 64'(NPIX));
        start = 1'b0;
        layer_sel = lsel;
        ifm_valid = 1'b0;
    endtask

    task automatic fill_uniform(input logic [15:0] x, input logic [15:0] w0, input logic [15:0] w1, input int b);
        for (int i = 0; i < NBEAT; i++) px[i] = x;
        for (int c = 0; c < CHIN; c++)
            for (int lane = 0; lane < DSP_NO; lane++) begin
                rom[0][c][lane] = w0;
                rom[1][c][lane] = w1;
            end
        for (int lane = 0; lane < DSP_NO; lane++) bias_l[lane] = b;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NBEAT; i++) px[i] = 16'(int'($urandom_range(0, 8192)) - 4096);
        for (int l = 0; l < LAYERS; l++)
            for (int c = 0; c < CHIN; c++)
                for (int lane = 0; lane < DSP_NO; lane++) rom[l][c][lane] = 16'($urandom);
        for (int lane = 0; lane < DSP_NO; lane++) bias_l[lane] = int'($urandom_range(0, 1 << 27)) - (1 << 26);
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] w;
        int          b;
        logic [15:0] e;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{x: 16'h1000, w: 16'h4000, b: 0,          e: 16'h4000};
        tbl[1] = '{x: 16'h1000, w: 16'hC000, b: 0,          e: 16'h0000};
        tbl[2] = '{x: 16'h0000, w: 16'h0000, b: 32'h1C000,  e: 16'h0007};
        tbl[3] = '{x: 16'h7FFF, w: 16'h7FFF, b: 0,          e: 16'h7FFF};
        tbl[4] = '{x: 16'hF000, w: 16'hC000, b: 0,          e: 16'h4000};
        tbl[5] = '{x: 16'h0100, w: 16'h4000, b: 0,          e: 16'h0400};
        tbl[6] = '{x: 16'h8000, w: 16'h8000, b: 0,          e: 16'h7FFF};
        tbl[7] = '{x: 16'h0000, w: 16'h0000, b: -1,         e: 16'h0000};

        fill_uniform(16'h0, 16'h0, 16'h0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_zero("idle");

        // Uniform vectors on layer 0; layer 1 holds different weights
        for (int k = 0; k < 8; k++) begin
            fill_uniform(tbl[k].x, tbl[k].w, tbl[k].w ^ 16'h5555, tbl[k].b);
            for (int p = 0; p < NPIX; p++) exp_pix[p] = {4{tbl[k].e}};
            run_layer(1'b0, 1'b0, 1'b0, -1);
        end

        // Layer 1 with stalls and a start pulse while running
        fill_uniform(16'h1000, 16'h0000, 16'h4000, 0);
        for (int p = 0; p < NPIX; p++) exp_pix[p] = {4{16'h4000}};
        run_layer(1'b1, 1'b1, 1'b1, -1);

        // Random data against the reference model, with and without stalls
        for (int r = 0; r < 6; r++) begin
            fill_random();
            for (int p = 0; p < NPIX; p++) exp_pix[p] = model_pixel(r % 2, p);
            run_layer(1'(r % 2), 1'b0, 1'b0, -1);
            run_layer(1'(r % 2), 1'b1, r == 3, -1);
        end

        // Reset during pixel 2, then a clean restart
        fill_random();
        for (int p = 0; p < NPIX; p++) exp_pix[p] = model_pixel(0, p);
        run_layer(1'b0, 1'b0, 1'b0, 9);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_quiet", 64'({ofm_valid, done, busy}), 64'(0));
            @(posedge clk); #1;
        end
        run_layer(1'b0, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/expand_1x1_engine.md
# expand_1x1_engine

Parametrised 1×1 convolution engine for fire-module expand layers: one engine serves any number of layers (`LAYERS`) by selecting a per-layer weight/bias context at start. It streams input channels one pixel-channel per beat, applies `DSP_NO` parallel multiply-accumulate lanes, and adds bias. It then applies ReLU with saturating fixed-point requantisation, and emits one output vector of `DSP_NO` channels per pixel. Successive pixels accumulate back-to-back with no clear bubble. It sits between the squeeze-layer output buffer and the expand-layer concatenation buffer.

## Interface
- `WIDTH`, 16: activation/weight width, signed.
- `DSP_NO`, 64: output channels (MAC lanes).
- `CHIN`, 16: input channels per pixel (≥2).
- `WOUT`, 64: output feature-map side; pixels per layer = `WOUT*WOUT`.
- `FRAC`, 14: fractional bits of activations and weights.
- `LAYERS`, 2: number of selectable layer contexts (≥2).
- `clk` in 1: clock.
- `rst` in 1: reset. **Asynchronous, active-high.**
- `start` in 1: single-cycle start request; honoured only in IDLE.
- `layer_sel` in `$clog2(LAYERS)`: layer context; sampled when `start` is accepted.
- `ifm_valid` in 1: `ifm` beat valid.
- `ifm` in `WIDTH`: one input-channel value; channel order is 0..`CHIN-1` within each pixel.
- `ifm_ready` out 1: high in RUN only.
- `w_layer` out `$clog2(LAYERS)`: latched layer index to the weight ROM and bias table.
- `w_addr` out `$clog2(CHIN)`: current channel index to the weight ROM.
- `w_data` in `DSP_NO*WIDTH`: combinational ROM data for (`w_layer`, `w_addr`); lane i = bits [i*WIDTH +: WIDTH].
- `bias` in `DSP_NO*2*WIDTH`: per-lane bias in Q(2·FRAC) product scale; stable while busy.
- `ofm` out `DSP_NO*WIDTH`: output vector, held between valids.
- `ofm_valid` out 1: one-cycle pulse per pixel.
- `busy` out 1: engine active.
- `done` out 1: one-cycle pulse at layer end.

## Operation
- **States:**
  - IDLE → RUN on `start`: latch `layer_sel` into `w_layer` and clear `ch_cnt` and `pix_cnt`.
  - RUN → FLUSH when the last beat of pixel `WOUT*WOUT-1` is accepted.
  - FLUSH → IDLE when the last `ofm_valid` fires.
- `start` while not IDLE is ignored.
- **Beat acceptance:** a beat is accepted when `ifm_valid && ifm_ready`.
  - `w_addr` = `ch_cnt` combinationally.
  - `ch_cnt` wraps `CHIN-1`→0 and increments `pix_cnt` on the wrap.
  - Cycles with no accepted beat advance nothing; stalls are lossless.
- **Stage 1:** register `ifm`, `w_data`, a first-channel flag and a last-channel flag on each accepted beat. A stage-1 valid bit gates stage 2.
- **Stage 2:** each lane computes the signed product `ifm*w`, `2*WIDTH` bits.
  - Accumulator width is `2*WIDTH+$clog2(CHIN)`, signed.
  - When the first-channel flag is set, the accumulator loads the product; otherwise it adds the product.
- **Stage 3:** on the last-channel flag, compute `sum = acc + sign-extended bias`.
  - `sum < 0` → 0 (ReLU).
  - Otherwise `q = sum >>> FRAC`; if `q > 2^(WIDTH-1)-1`, output `2^(WIDTH-1)-1`; else output `q[WIDTH-1:0]`.
  - Register the result into `ofm` and pulse `ofm_valid`.
- `ofm` has no backpressure; the consumer must accept every `ofm_valid`.
- `busy` = state != IDLE.
- `done` is asserted in the same cycle as the final `ofm_valid`.

## Timing
- **Reset** (async, immediate): state IDLE, counters 0, `w_layer` 0, accumulators 0, stage valids 0.
  - `ofm` = 0, `ofm_valid` = 0, `done` = 0, `busy` = 0, `ifm_ready` = 0.
  - Reset mid-layer discards the partial pixel and emits no `done`.
- **Start:** `start` accepted at edge t → `busy` and `ifm_ready` high from cycle t+1.
- **Latency:** last channel beat accepted in cycle t → `ofm_valid` high in cycle t+3.
- **Throughput:** with `ifm_valid` held high, `ofm_valid` pulses every `CHIN` cycles.
- **End of layer:** `ifm_ready` drops in the cycle after the final beat is accepted. `done` pulses 3 cycles after the final beat, and `busy` falls the following cycle.
- **Restart:** `start` in the first IDLE cycle after `done` is accepted.

## Test plan
All scenarios use `CHIN`=4, `WOUT`=2, `DSP_NO`=4, `FRAC`=14, `LAYERS`=2.
- **Unity weights:** all weights 0x4000, bias 0, `ifm` 0x1000 for every beat → each `ofm` lane 0x4000. `ofm_valid` fires 3 cycles after each 4th beat. 4 pulses total, then `done` coincident with the 4th.
- **ReLU:** weights 0xC000, `ifm` 0x1000 → all lanes 0x0000. Bias 32'h0001_C000 with weights 0 → all lanes 0x0007.
- **Saturation:** `ifm` 0x7FFF, weights 0x7FFF → all lanes 0x7FFF, no wrap.
- **Stalls and layer select:** `layer_sel`=1 with `ifm_valid` deasserted for 3 cycles mid-pixel and 1 cycle between pixels → `w_layer`=1 throughout. `ofm` values are identical to the no-stall run, and `w_addr` holds during stalls.
- **Start while busy:** `start` pulsed during RUN → ignored, and the pixel count still ends at 4.
- **Reset mid-layer:** `rst` asserted during pixel 2 → all outputs 0 immediately, and no `done`. A new `start` then produces 4 correct pixels from pixel 0.
